mac_dot_ctrl: RTL

MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

---
 rtl/mac_dot_pkg.sv | 16 +
 rtl/mac_dot_acc.sv | 67 ++++++
 rtl/mac_dot_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mac_dot_pkg.sv
// Shared types and constants for the dot-product MAC controller.
// Holds the controller FSM state enum and operand/product widths.
// No logic; imported by mac_dot_acc and mac_dot_ctrl.
package mac_dot_pkg;

    localparam int PROD_W = 16;
    localparam int OPND_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_acc.sv
// Product register plus wide accumulator with sticky overflow (saturation under MAC_DOT_SATURATE_EN).
// Latency: product registered 1 cycle after i_ld, accumulated on the following edge.
// Backpressure: none; the controller only asserts i_ld on accepted pairs.
module mac_dot_acc
    import mac_dot_pkg::*;
#(
    parameter int ACC_W = 16   // must be >= PROD_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_ovf
);

    logic [PROD_W-1:0] r_prod;
    logic              r_pv;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]    w_sum;

    // Operands are zero-extended so the multiply is evaluated at full product width.
    assign w_prod = {{(PROD_W-OPND_W){1'b0}}, i_a} * {{(PROD_W-OPND_W){1'b0}}, i_b};
    // One spare bit on top captures the carry-out of the accumulate.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, r_prod};

    // Product stage and accumulator; clear wins so a new job never sees stale state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else if (i_clr) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pv <= i_ld;
            if (i_ld) begin
                r_prod <= w_prod;
            end
            if (r_pv) begin
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
`ifdef MAC_DOT_SATURATE_EN
                    r_acc <= '1;
`else
                    r_acc <= w_sum[ACC_W-1:0];
`endif
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
            end
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product job controller: counts len_m1+1 operand pairs into mac_dot_acc, presents result (MAC_DOT_SATURATE_EN selects saturation).
// Latency: res_valid first asserts 2 cycles after the final pair handshake (one DRAIN cycle).
// Backpressure: in_valid gaps stall the job; result held in DONE until res_ready.
module mac_dot_ctrl
    import mac_dot_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int ACC_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len_m1,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [OPND_W-1:0] i_in_a,
    input  logic [OPND_W-1:0] i_in_b,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic              o_res_ovf,
    output logic              o_busy
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_accept;
    logic             w_last;
    logic             w_clr;
    logic [ACC_W-1:0] w_acc;
    logic             w_ovf;

    assign w_accept = r_in_ready & i_in_valid;
    assign w_last   = w_accept & (r_cnt == r_len);
    // Accumulator clears on job start and again on result handshake so IDLE shows no stale flag.
    assign w_clr    = ((r_state == IDLE) & i_start) | ((r_state == DONE) & i_res_ready);

    // Job FSM with registered handshake and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_len      <= i_len_m1;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_in_ready <= 1'b0;
                        r_state    <= DRAIN;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    mac_dot_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_ld    (w_accept),
        .i_a     (i_in_a),
        .i_b     (i_in_b),
        .o_acc   (w_acc),
        .o_ovf   (w_ovf)
    );

    assign o_in_ready  = r_in_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_valid ? w_acc : '0;
    assign o_res_ovf   = w_ovf;
    assign o_busy      = r_busy;

endmodule
